// File: rtl/stopwatch_if.sv
// Control and display handshake between the stopwatch core and its button/display neighbours.
interface stopwatch_if;
  logic        i_run_stop;
  logic        i_clear;
  logic        i_lap;
  logic [23:0] o_time;
  logic        o_running;
  logic        o_tick;
  logic        o_lap_held;

  modport master (
    output i_run_stop, i_clear, i_lap,
    input  o_time, o_running, o_tick, o_lap_held
  );

  modport slave (
    input  i_run_stop, i_clear, i_lap,
    output o_time, o_running, o_tick, o_lap_held
  );
endinterface

// File: rtl/stopwatch_core.sv
// Centisecond time base, RUN/STOP/CLEAR control and cascaded msec/sec/min/hour counters.
// Define LAP_HOLD_EN to build the lap snapshot register driven by i_lap.
module stopwatch_core #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input logic       clk,
  input logic       reset,
  stopwatch_if.slave bus
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic             running;
  logic [6:0]       msec;
  logic [5:0]       sec;
  logic [5:0]       min;
  logic [4:0]       hour;
  logic [23:0]      live;
  logic             msec_wrap;
  logic             sec_wrap;
  logic             min_wrap;

  assign live      = {hour, min, sec, msec};
  assign msec_wrap = (msec == 7'd99);
  assign sec_wrap  = (sec == 6'd59);
  assign min_wrap  = (min == 6'd59);

  // The divider only moves in RUN, so a partial interval survives a stop and resumes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= STOP;
      div     <= '0;
      tick    <= 1'b0;
      running <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        STOP: begin
          if (bus.i_run_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (bus.i_clear) begin
            state <= CLEAR;
          end
        end
        RUN: begin
          if (div == DIV_LAST) begin
            div  <= '0;
            tick <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
          if (bus.i_run_stop) begin
            state   <= STOP;
            running <= 1'b0;
          end
        end
        CLEAR: begin
          div   <= '0;
          state <= STOP;
        end
        default: begin
          state   <= STOP;
          running <= 1'b0;
        end
      endcase
    end
  end

  // A tick raised on the RUN->STOP edge is still consumed here on the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msec <= '0;
      sec  <= '0;
      min  <= '0;
      hour <= '0;
    end else if (state == CLEAR) begin
      msec <= '0;
      sec  <= '0;
      min  <= '0;
      hour <= '0;
    end else if (tick) begin
      msec <= msec_wrap ? 7'd0 : msec + 7'd1;
      if (msec_wrap) begin
        sec <= sec_wrap ? 6'd0 : sec + 6'd1;
        if (sec_wrap) begin
          min <= min_wrap ? 6'd0 : min + 6'd1;
          if (min_wrap) begin
            hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
          end
        end
      end
    end
  end

`ifdef LAP_HOLD_EN
  logic [23:0] snap;
  logic        lap_held;

  // Capture only from RUN; releasing the hold is allowed from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap     <= '0;
      lap_held <= 1'b0;
    end else if (state == CLEAR) begin
      lap_held <= 1'b0;
    end else if (bus.i_lap) begin
      if (lap_held) begin
        lap_held <= 1'b0;
      end else if (state == RUN) begin
        snap     <= live;
        lap_held <= 1'b1;
      end
    end
  end

  assign bus.o_time     = lap_held ? snap : live;
  assign bus.o_lap_held = lap_held;
`else
  logic unused_lap;
  assign unused_lap     = bus.i_lap;
  assign bus.o_time     = live;
  assign bus.o_lap_held = 1'b0;
`endif

  assign bus.o_tick    = tick;
  assign bus.o_running = running;

endmodule
